// File: rtl/aclint_pkg.sv
// aclint_pkg: shared address map, hart strides, decode result type and
// a byte-lane merge helper for the ACLINT machine timer / software IRQ block.
package aclint_pkg;

   localparam int ADDR_W     = 24;
   localparam int HART_IDX_W = 4;   // up to 16 harts

   // Register window offsets inside the ACLINT address range
   localparam logic [ADDR_W-1:0] MSIP_BASE     = 24'h00_0000;
   localparam logic [ADDR_W-1:0] MTIMECMP_BASE = 24'h00_4000;
   localparam logic [ADDR_W-1:0] MTIME_LO      = 24'h00_BFF8;
   localparam logic [ADDR_W-1:0] MTIME_HI      = 24'h00_BFFC;
   localparam logic [ADDR_W-1:0] SSWI_BASE     = 24'h00_C000;

   // Byte distance between consecutive harts in each window
   localparam int MSIP_STRIDE     = 4;
   localparam int MTIMECMP_STRIDE = 8;
   localparam int SSWI_STRIDE     = 4;

   typedef enum logic [2:0] {
      DEC_NONE,
      DEC_MSIP,
      DEC_MTIMECMP_LO,
      DEC_MTIMECMP_HI,
      DEC_MTIME_LO,
      DEC_MTIME_HI,
      DEC_SSWI
   } dec_e;

   // Replace the bytes of old_word selected by mask with those of new_word
   function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  mask);
      logic [31:0] res;
      for (int b = 0; b < 4; b++) begin
         res[8*b +: 8] = mask[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/aclint_mtimer.sv
// aclint_mtimer: programmable prescaler plus the 64-bit mtime counter with a
// byte-masked software write port. A write in the same cycle as a tick wins
// for all 64 bits; the prescaler keeps running through writes.
module aclint_mtimer
   import aclint_pkg::*;
#(
   parameter int PRESCALE_W = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [PRESCALE_W-1:0] div,
   input  logic [3:0]            wr_lo_mask,
   input  logic [3:0]            wr_hi_mask,
   input  logic [31:0]           wdata,
   output logic [63:0]           mtime,
   output logic                  tick
);

   logic [PRESCALE_W-1:0] presc_reg;
   logic [PRESCALE_W-1:0] presc_next;
   logic [PRESCALE_W-1:0] terminal;
   logic [63:0]           mtime_reg;
   logic [63:0]           mtime_next;

   // Terminal count: div 0 and 1 both tick every cycle. Using >= lets a
   // counter stranded above a freshly lowered div wrap on the next cycle.
   always_comb begin
      terminal   = (div > PRESCALE_W'(1)) ? (div - PRESCALE_W'(1)) : '0;
      tick       = (presc_reg >= terminal);
      presc_next = tick ? '0 : (presc_reg + PRESCALE_W'(1));
   end

   // mtime next value: software write (merged onto pre-increment value) beats tick
   always_comb begin
      mtime_next = mtime_reg;
      if ((wr_lo_mask != 4'b0000) || (wr_hi_mask != 4'b0000)) begin
         mtime_next = {byte_merge(mtime_reg[63:32], wdata, wr_hi_mask),
                       byte_merge(mtime_reg[31:0],  wdata, wr_lo_mask)};
      end else if (tick) begin
         mtime_next = mtime_reg + 64'd1;
      end
   end

   // Prescaler and mtime state registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc_reg <= '0;
         mtime_reg <= '0;
      end else begin
         presc_reg <= presc_next;
         mtime_reg <= mtime_next;
      end
   end

   assign mtime = mtime_reg;

endmodule

// File: rtl/aclint_mc.sv
// aclint_mc: multi-hart ACLINT (MTIMER + MSWI, optional SSWI) as a
// one-cycle-latency MMIO slave. Optional feature macro: ACLINT_SSWI_EN
// enables the setssip window at 0xC000 and the ssip_set pulses.
module aclint_mc
   import aclint_pkg::*;
#(
   parameter int NUM_HARTS  = 1,
   parameter int PRESCALE_W = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  valid,
   input  logic [23:0]           addr,
   input  logic [3:0]            wmask,
   input  logic [31:0]           wdata,
   input  logic [PRESCALE_W-1:0] div,
   output logic [31:0]           rdata,
   output logic                  is_valid,
   output logic                  ready,
   output logic [NUM_HARTS-1:0]  msip_irq,
   output logic [NUM_HARTS-1:0]  mtip_irq,
   output logic [NUM_HARTS-1:0]  ssip_set,
   output logic [63:0]           mtime
);

   // End (exclusive) of each per-hart window; the msip window starts at 0
   localparam logic [ADDR_W-1:0] MSIP_END =
      MSIP_BASE + ADDR_W'(MSIP_STRIDE * NUM_HARTS);
   localparam logic [ADDR_W-1:0] MTIMECMP_END =
      MTIMECMP_BASE + ADDR_W'(MTIMECMP_STRIDE * NUM_HARTS);
`ifdef ACLINT_SSWI_EN
   localparam logic [ADDR_W-1:0] SSWI_END =
      SSWI_BASE + ADDR_W'(SSWI_STRIDE * NUM_HARTS);
`endif

   dec_e                  dec;
   logic [HART_IDX_W-1:0] hart_idx;
   logic                  accept;
   logic                  wr_en;
   logic [31:0]           rd_data;
   logic                  ready_reg;
   logic [31:0]           rdata_reg;
   logic                  cmp_upd_reg;
   logic                  tick;
   logic [3:0]            mtime_lo_wmask;
   logic [3:0]            mtime_hi_wmask;
   logic [63:0]           mtimecmp_val [NUM_HARTS];

   // Address decode: register class and hart index; misaligned never decodes
   always_comb begin
      dec      = DEC_NONE;
      hart_idx = '0;
      if (addr[1:0] == 2'b00) begin
         if (addr < MSIP_END) begin
            dec      = DEC_MSIP;
            hart_idx = HART_IDX_W'(addr >> 2);
         end else if ((addr >= MTIMECMP_BASE) && (addr < MTIMECMP_END)) begin
            dec      = addr[2] ? DEC_MTIMECMP_HI : DEC_MTIMECMP_LO;
            hart_idx = HART_IDX_W'((addr - MTIMECMP_BASE) >> 3);
         end else if (addr == MTIME_LO) begin
            dec = DEC_MTIME_LO;
         end else if (addr == MTIME_HI) begin
            dec = DEC_MTIME_HI;
         end
`ifdef ACLINT_SSWI_EN
         else if ((addr >= SSWI_BASE) && (addr < SSWI_END)) begin
            dec      = DEC_SSWI;
            hart_idx = HART_IDX_W'((addr - SSWI_BASE) >> 2);
         end
`endif
      end
   end

   assign is_valid = valid && (dec != DEC_NONE);
   // The ready cycle blocks a held request from committing twice
   assign accept   = is_valid && !ready_reg;
   assign wr_en    = accept && (wmask != 4'b0000);

   assign mtime_lo_wmask = (wr_en && (dec == DEC_MTIME_LO)) ? wmask : 4'b0000;
   assign mtime_hi_wmask = (wr_en && (dec == DEC_MTIME_HI)) ? wmask : 4'b0000;

   aclint_mtimer #(
      .PRESCALE_W (PRESCALE_W)
   ) u_mtimer (
      .clk        (clk),
      .reset      (reset),
      .div        (div),
      .wr_lo_mask (mtime_lo_wmask),
      .wr_hi_mask (mtime_hi_wmask),
      .wdata      (wdata),
      .mtime      (mtime),
      .tick       (tick)
   );

   // Read data mux, evaluated on the current (pre-write) register values
   always_comb begin
      rd_data = '0;
      case (dec)
         DEC_MSIP: begin
            for (int h = 0; h < NUM_HARTS; h++) begin
               if (hart_idx == HART_IDX_W'(h)) rd_data = {31'b0, msip_irq[h]};
            end
         end
         DEC_MTIMECMP_LO: begin
            for (int h = 0; h < NUM_HARTS; h++) begin
               if (hart_idx == HART_IDX_W'(h)) rd_data = mtimecmp_val[h][31:0];
            end
         end
         DEC_MTIMECMP_HI: begin
            for (int h = 0; h < NUM_HARTS; h++) begin
               if (hart_idx == HART_IDX_W'(h)) rd_data = mtimecmp_val[h][63:32];
            end
         end
         DEC_MTIME_LO: rd_data = mtime[31:0];
         DEC_MTIME_HI: rd_data = mtime[63:32];
         default:      rd_data = '0;
      endcase
   end

   // Handshake: one-cycle ready, rdata captured at the accept edge.
   // cmp_upd_reg marks cycles where mtime or mtimecmp may have just changed,
   // so the comparators only re-evaluate when their inputs moved.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ready_reg   <= 1'b0;
         rdata_reg   <= '0;
         cmp_upd_reg <= 1'b0;
      end else begin
         ready_reg   <= accept;
         cmp_upd_reg <= tick || wr_en;
         if (accept) rdata_reg <= rd_data;
      end
   end

   assign ready = ready_reg;
   assign rdata = rdata_reg;

   // Per-hart msip, mtimecmp and timer comparator
   for (genvar gi = 0; gi < NUM_HARTS; gi++) begin : g_hart
      logic        hart_sel;
      logic        msip_reg;
      logic        mtip_reg;
      logic [63:0] mtimecmp_reg;

      assign hart_sel = (hart_idx == HART_IDX_W'(gi));

      // Software-visible registers and registered timer compare
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            msip_reg     <= 1'b0;
            mtip_reg     <= 1'b0;
            mtimecmp_reg <= '1;
         end else begin
            if (wr_en && hart_sel && (dec == DEC_MSIP) && wmask[0]) begin
               msip_reg <= wdata[0];
            end
            if (wr_en && hart_sel && (dec == DEC_MTIMECMP_LO)) begin
               mtimecmp_reg[31:0] <= byte_merge(mtimecmp_reg[31:0], wdata, wmask);
            end
            if (wr_en && hart_sel && (dec == DEC_MTIMECMP_HI)) begin
               mtimecmp_reg[63:32] <= byte_merge(mtimecmp_reg[63:32], wdata, wmask);
            end
            if (cmp_upd_reg) begin
               mtip_reg <= (mtime >= mtimecmp_reg);
            end
         end
      end

      assign msip_irq[gi]     = msip_reg;
      assign mtip_irq[gi]     = mtip_reg;
      assign mtimecmp_val[gi] = mtimecmp_reg;
   end

`ifdef ACLINT_SSWI_EN
   logic [NUM_HARTS-1:0] ssip_reg;

   // One-cycle setssip pulse, coincident with ready
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ssip_reg <= '0;
      end else if (wr_en && (dec == DEC_SSWI) && wmask[0] && wdata[0]) begin
         ssip_reg <= NUM_HARTS'(1) << hart_idx;
      end else begin
         ssip_reg <= '0;
      end
   end

   assign ssip_set = ssip_reg;
`else
   assign ssip_set = '0;
`endif

endmodule
